// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned RD_W  = 5;
    localparam int unsigned CNT_W = 5;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } muldiv_state_e;

    function automatic logic is_div(input muldiv_op_e op);
        return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide
// on magnitudes over 32 steps, with a fast path for divide-by-zero and overflow.
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [2:0]      i_op,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic [RD_W-1:0] i_rd,
    input  logic            i_flush,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result,
    output logic [RD_W-1:0] o_rd
);

    localparam logic [CNT_W-1:0] CNT_LAST = '1;

    muldiv_state_e     r_state;
    muldiv_state_e     w_state_nx;
    logic              r_valid;
    logic              r_ready;
    muldiv_op_e        r_op;
    logic [RD_W-1:0]   r_rd;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_sign_q;
    logic              r_sign_r;
    logic [XLEN-1:0]   r_opb;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_result;

    muldiv_op_e        w_op;
    logic              w_rs1_signed;
    logic              w_rs2_signed;
    logic              w_s1;
    logic              w_s2;
    logic [XLEN-1:0]   w_mag1;
    logic [XLEN-1:0]   w_mag2;
    logic              w_div0;
    logic              w_ovf;
    logic              w_fast;
    logic [XLEN-1:0]   w_fast_res;
    logic              w_accept;

    logic [XLEN:0]     w_mul_sum;
    logic [XLEN:0]     w_rem_sh;
    logic [XLEN:0]     w_diff;
    logic [2*XLEN-1:0] w_step;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quot;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_final;

    assign o_ready  = r_ready;
    assign o_valid  = r_valid;
    assign o_result = r_result;
    assign o_rd     = r_rd;

    // Operand decode: signedness, magnitudes and fast-path detection
    always_comb begin
        w_op         = muldiv_op_e'(i_op);
        w_rs1_signed = (w_op == OP_MUL) || (w_op == OP_MULH) || (w_op == OP_MULHSU)
                    || (w_op == OP_DIV) || (w_op == OP_REM);
        w_rs2_signed = (w_op == OP_MUL) || (w_op == OP_MULH)
                    || (w_op == OP_DIV) || (w_op == OP_REM);
        w_s1         = w_rs1_signed & i_rs1[XLEN-1];
        w_s2         = w_rs2_signed & i_rs2[XLEN-1];
        w_mag1       = w_s1 ? -i_rs1 : i_rs1;
        w_mag2       = w_s2 ? -i_rs2 : i_rs2;
        w_div0       = is_div(w_op) && (i_rs2 == '0);
        w_ovf        = ((w_op == OP_DIV) || (w_op == OP_REM))
                    && (i_rs1 == 32'h8000_0000) && (i_rs2 == '1);
        w_fast       = w_div0 | w_ovf;
        if (w_div0)
            w_fast_res = ((w_op == OP_REM) || (w_op == OP_REMU)) ? i_rs1 : '1;
        else
            w_fast_res = (w_op == OP_DIV) ? 32'h8000_0000 : '0;
    end

    // One radix-2 step of the shared accumulator, plus final sign fix-up
    always_comb begin
        w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opb} : '0);
        w_rem_sh  = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
        w_diff    = w_rem_sh - {1'b0, r_opb};
        if (is_div(r_op)) begin
            if (w_diff[XLEN])
                w_step = {w_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
            else
                w_step = {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
        end else begin
            w_step = {w_mul_sum, r_acc[XLEN-1:1]};
        end
        w_prod = r_sign_q ? -w_step : w_step;
        w_quot = r_sign_q ? -w_step[XLEN-1:0] : w_step[XLEN-1:0];
        w_rem  = r_sign_r ? -w_step[2*XLEN-1:XLEN] : w_step[2*XLEN-1:XLEN];
        case (r_op)
            OP_MUL:                       w_final = w_prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_final = w_prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              w_final = w_quot;
            default:                      w_final = w_rem;
        endcase
    end

    // Next-state logic; flush wins over accept and handoff
    always_comb begin
        w_state_nx = r_state;
        w_accept   = 1'b0;
        if (i_flush) begin
            w_state_nx = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_valid) begin
                        w_accept   = 1'b1;
                        w_state_nx = w_fast ? ST_DONE : ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (r_cnt == CNT_LAST)
                        w_state_nx = ST_DONE;
                end
                ST_DONE: begin
                    if (i_ready)
                        w_state_nx = ST_IDLE;
                end
                default: w_state_nx = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            r_state <= w_state_nx;
            r_valid <= (w_state_nx == ST_DONE);
            r_ready <= (w_state_nx == ST_IDLE);
        end
    end

    // Mul keeps multiplicand in r_opb; div keeps the divisor there
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_op     <= OP_MUL;
            r_rd     <= '0;
            r_cnt    <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_opb    <= '0;
            r_acc    <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_op     <= w_op;
            r_rd     <= i_rd;
            r_cnt    <= '0;
            r_sign_q <= w_s1 ^ w_s2;
            r_sign_r <= w_s1;
            r_opb    <= is_div(w_op) ? w_mag2 : w_mag1;
            r_acc    <= {{XLEN{1'b0}}, (is_div(w_op) ? w_mag1 : w_mag2)};
            if (w_fast)
                r_result <= w_fast_res;
        end else if ((r_state == ST_CALC) && !i_flush) begin
            r_acc <= w_step;
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_LAST)
                r_result <= w_final;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed table, randomized ops against an
// arithmetic reference model, and handshake/flush/reset sequences.
module tb_muldiv_unit;

    logic        i_clk;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic [2:0]  i_op;
    logic [31:0] i_rs1;
    logic [31:0] i_rs2;
    logic [4:0]  i_rd;
    logic        i_flush;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_result;
    logic [4:0]  o_rd;

    int checks = 0;
    int errors = 0;

    muldiv_unit dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_op    (i_op),
        .i_rs1   (i_rs1),
        .i_rs2   (i_rs2),
        .i_rd    (i_rd),
        .i_flush (i_flush),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_result(o_result),
        .o_rd    (o_rd)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
    } vec_t;

    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      ub;
        logic [63:0] p;
        logic [31:0] r;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ub  = longint'({32'b0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        r   = '0;
        case (op)
            3'd0: begin p = 64'(sa * sb); r = p[31:0]; end
            3'd1: begin p = 64'(sa * sb); r = p[63:32]; end
            3'd2: begin p = 64'(sa * ub); r = p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
            3'd4: r = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: r = (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic bit is_fast(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        return op[2] && ((b == 0) || ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (o_ready !== 1'b1 && n < 100) begin
            @(posedge i_clk); #1; n++;
        end
        if (n >= 100) chk("ready_timeout", 32'(o_ready), 32'h1);
    endtask

    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rd);
        wait_ready();
        @(negedge i_clk);
        i_valid = 1'b1; i_op = op; i_rs1 = a; i_rs2 = b; i_rd = rd;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (o_valid !== 1'b1 && lat < 100) begin
            @(posedge i_clk); #1; lat++;
        end
    endtask

    task automatic handoff();
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        i_ready = 1'b0;
        chk("valid_drop", 32'(o_valid), 32'h0);
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp);
        int lat;
        start_op(op, a, b, rd);
        wait_valid(lat);
        chk("latency", 32'(lat), is_fast(op, a, b) ? 32'd0 : 32'd32);
        chk("result", o_result, exp);
        chk("rd", 32'(o_rd), 32'(rd));
        handoff();
    endtask

    vec_t vecs[$];

    initial begin
        int          lat;
        int          seen;
        logic [31:0] held_res;
        logic [4:0]  held_rd;
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        i_rst = 1'b1; i_valid = 1'b0; i_op = '0; i_rs1 = '0; i_rs2 = '0;
        i_rd = '0; i_flush = 1'b0; i_ready = 1'b0;
        repeat (3) @(posedge i_clk);
        #1 i_rst = 1'b0;
        chk("rst_ready", 32'(o_ready), 32'h1);
        chk("rst_valid", 32'(o_valid), 32'h0);
        chk("rst_result", o_result, 32'h0);
        chk("rst_rd", 32'(o_rd), 32'h0);

        vecs.push_back('{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB});
        vecs.push_back('{3'd1, 32'h0000_0007, 32'hFFFF_FFFD, 5'd6,  32'hFFFF_FFFF});
        vecs.push_back('{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE});
        vecs.push_back('{3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 5'd8,  32'hFFFF_FFFF});
        vecs.push_back('{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9,  32'h8000_0000});
        vecs.push_back('{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 5'd10, 32'hFFFF_FFFD});
        vecs.push_back('{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 5'd11, 32'hFFFF_FFFF});
        vecs.push_back('{3'd5, 32'd100,       32'd7,         5'd12, 32'd14});
        vecs.push_back('{3'd7, 32'd100,       32'd7,         5'd13, 32'd2});
        vecs.push_back('{3'd5, 32'd5,         32'd0,         5'd14, 32'hFFFF_FFFF});
        vecs.push_back('{3'd6, 32'd5,         32'd0,         5'd15, 32'd5});
        vecs.push_back('{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000});
        vecs.push_back('{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h0});
        vecs.push_back('{3'd4, 32'h8000_0000, 32'h0000_0001, 5'd18, 32'h8000_0000});
        vecs.push_back('{3'd0, 32'd3,         32'd4,         5'd0,  32'd12});
        foreach (vecs[i]) run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp);

        // Randomized ops, with divide special cases injected occasionally
        for (int n = 0; n < 60; n++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'h0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 20));
                default: ;
            endcase
            run_op(rop, ra, rb, 5'($urandom_range(0, 31)), ref_model(rop, ra, rb));
        end

        // i_valid held through CALC with new operands; then backpressure in DONE
        wait_ready();
        @(negedge i_clk);
        i_valid = 1'b1; i_op = 3'd4; i_rs1 = 32'hFFFF_FF9C; i_rs2 = 32'd7; i_rd = 5'd9;
        @(posedge i_clk); #1;
        i_op = 3'd0; i_rs1 = 32'd3; i_rs2 = 32'd5; i_rd = 5'd1;
        wait_valid(lat);
        i_valid = 1'b0;
        chk("bp_latency", 32'(lat), 32'd32);
        chk("bp_result", o_result, 32'hFFFF_FFF2);
        chk("bp_rd", 32'(o_rd), 32'd9);
        held_res = o_result;
        held_rd  = o_rd;
        for (int c = 0; c < 10; c++) begin
            @(posedge i_clk); #1;
            chk("bp_hold_result", o_result, held_res);
            chk("bp_hold_rd", 32'(o_rd), 32'(held_rd));
            chk("bp_hold_valid", 32'(o_valid), 32'h1);
            chk("bp_hold_ready", 32'(o_ready), 32'h0);
        end
        handoff();
        chk("bp_idle_ready", 32'(o_ready), 32'h1);

        // Flush at CALC count 10
        start_op(3'd3, 32'h1234_5678, 32'h9ABC_DEF0, 5'd3);
        repeat (10) @(posedge i_clk);
        #1 i_flush = 1'b1;
        @(posedge i_clk); #1;
        i_flush = 1'b0;
        chk("flush_valid", 32'(o_valid), 32'h0);
        chk("flush_ready", 32'(o_ready), 32'h1);
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge i_clk); #1;
            if (o_valid) seen++;
        end
        chk("flush_no_result", 32'(seen), 32'h0);
        run_op(3'd5, 32'd1000, 32'd33, 5'd21, 32'd30);

        // Flush overrides a simultaneous accept
        @(negedge i_clk);
        i_valid = 1'b1; i_flush = 1'b1; i_op = 3'd0; i_rs1 = 32'd2; i_rs2 = 32'd2; i_rd = 5'd2;
        @(posedge i_clk); #1;
        i_valid = 1'b0; i_flush = 1'b0;
        chk("flush_vs_accept", 32'(o_ready), 32'h1);

        // Reset while in DONE
        start_op(3'd7, 32'd100, 32'd7, 5'd4);
        wait_valid(lat);
        chk("rst_done_reached", 32'(o_valid), 32'h1);
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        chk("rst_done_valid", 32'(o_valid), 32'h0);
        chk("rst_done_ready", 32'(o_ready), 32'h1);
        chk("rst_done_result", o_result, 32'h0);
        chk("rst_done_rd", 32'(o_rd), 32'h0);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd31, 32'h4000_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
